// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm buzzer event decoder.
package alarm_pkg;

    localparam logic [1:0] CODE_ILLEGAL = 2'd0;
    localparam logic [1:0] CODE_B1      = 2'd1;
    localparam logic [1:0] CODE_B2      = 2'd2;
    localparam logic [1:0] CODE_B3      = 2'd3;

    localparam int         LEN_W   = 6;
    localparam logic [5:0] LEN_MAX = 6'd63;

    typedef enum logic {IDLE, MEAS} state_t;

    typedef struct packed {
        logic [1:0]       code;
        logic [LEN_W-1:0] len;
        logic             err;
    } evt_rec_t;

    localparam int REC_W = $bits(evt_rec_t);

    // Multi-hot (or empty) patterns map to the illegal code.
    function automatic logic [1:0] code_of(input logic [2:0] p);
        logic [1:0] c;
        case (p)
            3'b001:  c = CODE_B1;
            3'b010:  c = CODE_B2;
            3'b100:  c = CODE_B3;
            default: c = CODE_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Event record queue; head reads as zero while empty.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         wr_en, rd_en;

    // A push on a full queue is only taken when the head leaves the same edge.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alarm_event_decoder.sv
// Measures one-hot buzzer pulses, classifies them and queues one record per pulse.
module alarm_event_decoder
    import alarm_pkg::*;
#(
    parameter int NOM_LEN    = 31,
    parameter int LEN_TOL    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] buzz_in,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_code,
    output logic [5:0] evt_len,
    output logic       evt_err,
    output logic       overflow,
    output logic       busy
);

    localparam logic [5:0] LEN_LO = 6'(NOM_LEN - LEN_TOL);
    localparam logic [5:0] LEN_HI = 6'(NOM_LEN + LEN_TOL);

    state_t     state, state_nx;
    logic [2:0] buzz_q, pat, pat_nx;
    logic [5:0] len, len_nx;
    logic       rec_push, interrupted;
    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [REC_W-1:0] head;
    evt_rec_t   rec, head_rec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzz_q   <= '0;
            state    <= IDLE;
            pat      <= '0;
            len      <= '0;
            overflow <= 1'b0;
        end else if (ena) begin
            buzz_q <= buzz_in;
            state  <= state_nx;
            pat    <= pat_nx;
            len    <= len_nx;
            if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        pat_nx      = pat;
        len_nx      = len;
        rec_push    = 1'b0;
        interrupted = 1'b0;
        case (state)
            IDLE: begin
                if (buzz_q != 3'b000) begin
                    pat_nx   = buzz_q;
                    len_nx   = 6'd1;
                    state_nx = MEAS;
                end
            end
            MEAS: begin
                if (buzz_q == 3'b000) begin
                    rec_push = 1'b1;
                    state_nx = IDLE;
                end else if (buzz_q == pat) begin
                    len_nx = (len == LEN_MAX) ? LEN_MAX : len + 6'd1;
                end else begin
                    // Pattern switched without a gap: close the old pulse as interrupted.
                    rec_push    = 1'b1;
                    interrupted = 1'b1;
                    pat_nx      = buzz_q;
                    len_nx      = 6'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rec.code = code_of(pat);
        rec.len  = len;
        rec.err  = (rec.code == CODE_ILLEGAL) || (len < LEN_LO) || (len > LEN_HI) || interrupted;
    end

    assign fifo_push = rec_push && ena;
    assign fifo_pop  = evt_valid && evt_ready;

    event_fifo #(.DEPTH(FIFO_DEPTH), .W(REC_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    assign head_rec  = head;
    assign evt_valid = !fifo_empty && ena;
    assign evt_code  = head_rec.code;
    assign evt_len   = head_rec.len;
    assign evt_err   = head_rec.err;
    assign busy      = (state == MEAS);

endmodule

// File: tb/tb_alarm_event_decoder.sv
// Directed bench for alarm_event_decoder with a run-length reference model.
module tb_alarm_event_decoder;

    localparam int NOM   = 31;
    localparam int TOL   = 1;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [2:0] buzz_in = 3'b000;
    logic       evt_ready = 1'b0;
    logic       evt_valid, evt_err, overflow, busy;
    logic [1:0] evt_code;
    logic [5:0] evt_len;

    int checks = 0;
    int errors = 0;

    alarm_event_decoder #(.NOM_LEN(NOM), .LEN_TOL(TOL), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .buzz_in   (buzz_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_len   (evt_len),
        .evt_err   (evt_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: the sampled input stream is split into runs of one pattern;
    // each run closing produces a record one enabled edge after its first non-matching sample.
    typedef struct { int code; int len; int err; } mrec_t;
    mrec_t      mq[$];
    mrec_t      m_r;
    logic [2:0] m_prev, m_pat;
    int         m_cnt;
    bit         m_ovf, m_have, m_pop;

    function automatic mrec_t mk(input logic [2:0] p, input int n, input bit intr);
        mrec_t r;
        int    ones = $countones(p);
        r.code = 0;
        for (int i = 0; i < 3; i++) if (ones == 1 && p[i]) r.code = i + 1;
        r.len = n;
        r.err = (ones != 1 || n < NOM - TOL || n > NOM + TOL || intr) ? 1 : 0;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_prev = 0; m_pat = 0; m_cnt = 0; m_ovf = 0;
        end else if (ena) begin
            m_pop  = (mq.size() > 0) && evt_ready;
            m_have = 0;
            if (m_pat != 0 && m_prev != m_pat) begin
                m_r = mk(m_pat, m_cnt, m_prev != 0);
                m_have = 1;
            end
            if (m_prev == 0) m_pat = 0;
            else if (m_prev == m_pat) m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
            else begin m_pat = m_prev; m_cnt = 1; end
            if (m_pop) void'(mq.pop_front());
            if (m_have) begin
                if (mq.size() < DEPTH) mq.push_back(m_r);
                else m_ovf = 1;
            end
            m_prev = buzz_in;
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = (mq.size() > 0) && ena && !rst;
        chk("cmp.valid", evt_valid, ev);
        if (ev && evt_valid) begin
            chk("cmp.code", evt_code, mq[0].code);
            chk("cmp.len",  evt_len,  mq[0].len);
            chk("cmp.err",  evt_err,  mq[0].err);
        end
        chk("cmp.overflow", overflow, m_ovf);
        chk("cmp.busy", busy, (m_pat != 0) ? 1 : 0);
    end

    task automatic pulse(input logic [2:0] p, input int n);
        @(posedge clk); #1 buzz_in = p;
        repeat (n) @(posedge clk);
        #1 buzz_in = 3'b000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a head record, check it against literals, then accept it.
    task automatic take(input string nm, input int c, input int l, input int e);
        int n = 0;
        @(negedge clk);
        while (!evt_valid && n < 200) begin @(negedge clk); n++; end
        chk({nm, ".valid"}, evt_valid, 1);
        chk({nm, ".code"}, evt_code, c);
        chk({nm, ".len"}, evt_len, l);
        chk({nm, ".err"}, evt_err, e);
        evt_ready = 1'b1;
        @(posedge clk); #1 evt_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        idle(3);
        @(negedge clk);
        chk("rst.valid", evt_valid, 0);
        chk("rst.code", evt_code, 0);
        chk("rst.len", evt_len, 0);
        chk("rst.err", evt_err, 0);
        chk("rst.overflow", overflow, 0);
        chk("rst.busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        // Nominal buzzer2 pulse with latency pinning
        evt_ready = 1'b1;
        pulse(3'b010, 31);
        @(posedge clk); @(negedge clk);
        chk("lat.valid_k", evt_valid, 0);
        @(posedge clk); @(negedge clk);
        chk("lat.valid_k1", evt_valid, 1);
        chk("lat.code", evt_code, 2);
        chk("lat.len", evt_len, 31);
        chk("lat.err", evt_err, 0);
        @(negedge clk);
        chk("lat.popped", evt_valid, 0);
        evt_ready = 1'b0;
        idle(2);

        // Width window on buzzer1
        pulse(3'b001, 29); take("w29", 1, 29, 1);
        pulse(3'b001, 30); take("w30", 1, 30, 0);
        pulse(3'b001, 32); take("w32", 1, 32, 0);
        pulse(3'b001, 33); take("w33", 1, 33, 1);

        // Multi-hot
        pulse(3'b101, 31); take("multi", 0, 31, 1);

        // Interrupted pulse followed directly by a new pattern
        @(posedge clk); #1 buzz_in = 3'b001;
        repeat (10) @(posedge clk);
        #1 buzz_in = 3'b100;
        repeat (31) @(posedge clk);
        #1 buzz_in = 3'b000;
        take("intr.a", 1, 10, 1);
        take("intr.b", 3, 31, 0);

        // Overflow: fifth record dropped
        pulse(3'b001, 31); idle(1);
        pulse(3'b010, 31); idle(1);
        pulse(3'b100, 31); idle(1);
        pulse(3'b001, 31); idle(1);
        pulse(3'b010, 31); idle(3);
        chk("ovf.flag", overflow, 1);
        take("ovf.r0", 1, 31, 0);
        take("ovf.r1", 2, 31, 0);
        take("ovf.r2", 3, 31, 0);
        take("ovf.r3", 1, 31, 0);
        @(negedge clk);
        chk("ovf.drained", evt_valid, 0);
        chk("ovf.sticky", overflow, 1);

        // Saturation
        pulse(3'b001, 80); take("sat", 1, 63, 1);

        // Reset mid-pulse with a record queued and overflow set
        pulse(3'b010, 31); idle(3);
        @(posedge clk); #1 buzz_in = 3'b001;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst.valid", evt_valid, 0);
        chk("mrst.code", evt_code, 0);
        chk("mrst.len", evt_len, 0);
        chk("mrst.err", evt_err, 0);
        chk("mrst.overflow", overflow, 0);
        chk("mrst.busy", busy, 0);
        buzz_in = 3'b000;
        @(posedge clk); #1 rst = 1'b0;
        idle(5);
        chk("mrst.norec", evt_valid, 0);

        // Enable low for 5 cycles mid-pulse, with a queued record offered
        pulse(3'b100, 31); idle(3);
        @(posedge clk); #1 buzz_in = 3'b010;
        repeat (10) @(posedge clk);
        #1 ena = 1'b0; evt_ready = 1'b1;
        #1 chk("ena.valid_low", evt_valid, 0);
        repeat (5) @(posedge clk);
        #1 ena = 1'b1; evt_ready = 1'b0;
        repeat (21) @(posedge clk);
        #1 buzz_in = 3'b000;
        take("ena.held", 3, 31, 0);
        take("ena.rec", 2, 31, 0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
